image_loader: RTL and testbench

Upstream feeder for the network control FSM. While the FSM is in s_LOAD, the block accepts the binarised 28x28 MNIST image over an 8-bit input bus and packs it into an on-chip pixel buffer. It then raises load_done, which moves the FSM to s_LAYER_1. Layer 1 reads the buffer one row at a time through a combinational read port.

---
 rtl/bnn_pkg.sv | 27 ++
 rtl/image_loader_if.sv | 12 +
 rtl/image_loader.sv | 72 +++++++
 tb/tb_image_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and image geometry for the BNN datapath: the network FSM
// state encoding, image dimensions and the loader's internal states.
package bnn_pkg;

  typedef enum logic [2:0] {
    s_IDLE    = 3'd0,
    s_LOAD    = 3'd1,
    s_LAYER_1 = 3'd2,
    s_LAYER_2 = 3'd3,
    s_LAYER_3 = 3'd4
  } state_t;

  localparam int IMG_W   = 28;
  localparam int IMG_H   = 28;
  localparam int BUS_W   = 8;
  localparam int BUF_W   = IMG_W * IMG_H;
  localparam int N_BEATS = BUF_W / BUS_W;
  localparam int CNT_W   = $clog2(N_BEATS + 1);
  localparam int IDX_W   = $clog2(BUF_W);

  typedef enum logic [1:0] {
    L_IDLE,
    L_RECV,
    L_DONE
  } loader_state_t;

endpackage

// File: rtl/image_loader_if.sv
// Pixel load bus: beat data with a valid strobe, plus the completion level
// returned by the loader.
interface image_loader_if import bnn_pkg::*; ();

  logic [BUS_W-1:0] data_in;
  logic             data_valid;
  logic             load_done;

  modport master (output data_in, output data_valid, input load_done);
  modport slave  (input data_in, input data_valid, output load_done);

endinterface

// File: rtl/image_loader.sv
// Captures a binarised image beat by beat into a flat pixel buffer while the
// network FSM is in s_LOAD, and serves one row at a time to layer 1.
module image_loader import bnn_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  input  state_t              state,
  image_loader_if.slave       pix,
  input  logic [4:0]          rd_row,
  output logic [IMG_W-1:0]    rd_data,
  output logic [CNT_W-1:0]    beat_cnt
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);
  localparam logic [4:0]       ROW_LIM   = 5'(IMG_H);

  loader_state_t    lstate;
  logic [BUF_W-1:0] buffer;
  logic             done_q;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  // The entry cycle captures beat 0 even though beat_cnt is still stale.
  assign wr_idx = (lstate == L_IDLE) ? '0 : IDX_W'(beat_cnt) * IDX_W'(BUS_W);
  assign rd_idx = IDX_W'(rd_row) * IDX_W'(IMG_W);

  assign pix.load_done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lstate   <= L_IDLE;
      beat_cnt <= '0;
      done_q   <= 1'b0;
      buffer   <= '0;
    end else if (state != s_LOAD) begin
      lstate <= L_IDLE;
      done_q <= 1'b0;
    end else begin
      case (lstate)
        L_IDLE: begin
          lstate   <= L_RECV;
          beat_cnt <= pix.data_valid ? CNT_W'(1) : '0;
          if (pix.data_valid)
            buffer[wr_idx +: BUS_W] <= pix.data_in;
        end
        L_RECV: begin
          if (pix.data_valid) begin
            buffer[wr_idx +: BUS_W] <= pix.data_in;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              lstate <= L_DONE;
              done_q <= 1'b1;
            end
          end
        end
        L_DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          lstate <= L_IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_row < ROW_LIM)
      rd_data = buffer[rd_idx +: IMG_W];
  end

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: expected counts, done flags and row
// contents are queued as stimulus is driven and popped when sampled.
module tb_image_loader;
  import bnn_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  state_t           state;
  logic [4:0]       rd_row;
  logic [IMG_W-1:0] rd_data;
  logic [CNT_W-1:0] beat_cnt;

  image_loader_if pix_if ();

  image_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state),
    .pix      (pix_if),
    .rd_row   (rd_row),
    .rd_data  (rd_data),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [BUF_W-1:0] model_buf;
  logic [31:0]      exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic [7:0] d, input logic v);
    pix_if.data_in    = d;
    pix_if.data_valid = v;
    step();
  endtask

  // Drive one accepted beat k; the bench decides what the DUT must report.
  task automatic load_beat(input logic [7:0] d, input int k, input bit last);
    model_buf[k*BUS_W +: BUS_W] = d;
    exp_q.push_back(32'(k + 1));
    exp_q.push_back({31'd0, last});
    pix_if.data_in    = d;
    pix_if.data_valid = 1'b1;
    step();
    chk($sformatf("beat_cnt_k%0d", k), 32'(beat_cnt), exp_q.pop_front());
    chk($sformatf("load_done_k%0d", k), {31'd0, pix_if.load_done}, exp_q.pop_front());
    pix_if.data_valid = 1'b0;
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < IMG_H; r++) begin
      exp_q.push_back({4'd0, model_buf[r*IMG_W +: IMG_W]});
      rd_row = 5'(r);
      #1;
      chk($sformatf("%s_row%0d", tag, r), {4'd0, rd_data}, exp_q.pop_front());
    end
  endtask

  initial begin
    int k;
    int cyc;

    rst_n = 1'b1;
    state = s_IDLE;
    rd_row = '0;
    pix_if.data_in = '0;
    pix_if.data_valid = 1'b0;
    model_buf = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_load_done", {31'd0, pix_if.load_done}, 32'd0);
    chk("rst_rd_data", {4'd0, rd_data}, 32'd0);
    step();
    #3 rst_n = 1'b1;
    step();

    // Beats outside s_LOAD are ignored
    for (int i = 0; i < 10; i++) begin
      idle_cycle(8'hFF, 1'b1);
      chk("idle_beat_cnt", 32'(beat_cnt), 32'd0);
      chk("idle_load_done", {31'd0, pix_if.load_done}, 32'd0);
    end
    pix_if.data_valid = 1'b0;
    check_rows("idle");

    // Back-to-back load with data k
    state = s_LOAD;
    for (int i = 0; i < N_BEATS; i++)
      load_beat(8'(i), i, i == N_BEATS - 1);
    rd_row = 5'd0;
    #1 chk("b2b_row0_const", {4'd0, rd_data}, 32'h0302_0100);
    check_rows("b2b");

    // Leave s_LOAD; count holds, done drops
    state = s_IDLE;
    idle_cycle(8'h00, 1'b0);
    chk("exit_load_done", {31'd0, pix_if.load_done}, 32'd0);
    chk("exit_beat_cnt", 32'(beat_cnt), 32'(N_BEATS));

    // Toggling valid: beats on even cycles only
    state = s_LOAD;
    k = 0;
    cyc = 0;
    while (k < N_BEATS && cyc < 400) begin
      if (cyc % 2 == 0) begin
        load_beat(8'(k), k, k == N_BEATS - 1);
        k++;
      end else begin
        idle_cycle(8'h55, 1'b0);
        chk("tog_gap_cnt", 32'(beat_cnt), 32'(k));
        chk("tog_gap_done", {31'd0, pix_if.load_done}, 32'd0);
      end
      cyc++;
    end
    chk("tog_beats", 32'(k), 32'(N_BEATS));
    chk("tog_cycles", 32'(cyc), 32'd195);
    check_rows("tog");

    // Extra beats in L_DONE are dropped
    for (int i = 0; i < 5; i++) begin
      idle_cycle(8'hAA, 1'b1);
      chk("extra_beat_cnt", 32'(beat_cnt), 32'(N_BEATS));
      chk("extra_load_done", {31'd0, pix_if.load_done}, 32'd1);
    end
    state = s_LAYER_1;
    idle_cycle(8'hAA, 1'b0);
    chk("layer1_load_done", {31'd0, pix_if.load_done}, 32'd0);
    chk("layer1_beat_cnt", 32'(beat_cnt), 32'(N_BEATS));
    check_rows("post_extra");

    // Abandoned load after 40 beats, then a full all-ones reload
    state = s_LOAD;
    for (int i = 0; i < 40; i++)
      load_beat(8'hFF, i, 1'b0);
    state = s_IDLE;
    idle_cycle(8'hFF, 1'b1);
    chk("abandon_beat_cnt", 32'(beat_cnt), 32'd40);
    chk("abandon_load_done", {31'd0, pix_if.load_done}, 32'd0);
    check_rows("partial");
    state = s_LOAD;
    for (int i = 0; i < N_BEATS; i++)
      load_beat(8'hFF, i, i == N_BEATS - 1);
    check_rows("ones");
    rd_row = 5'd13;
    #1 chk("ones_row13_const", {4'd0, rd_data}, 32'h0FFF_FFFF);
    rd_row = 5'd28;
    #1 chk("oob_row28", {4'd0, rd_data}, 32'd0);
    rd_row = 5'd31;
    #1 chk("oob_row31", {4'd0, rd_data}, 32'd0);

    // Asynchronous reset in the middle of a load
    state = s_IDLE;
    idle_cycle(8'h00, 1'b0);
    state = s_LOAD;
    for (int i = 0; i < 50; i++)
      load_beat(~8'(i), i, 1'b0);
    rd_row = 5'd0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("arst_load_done", {31'd0, pix_if.load_done}, 32'd0);
    chk("arst_rd_data", {4'd0, rd_data}, 32'd0);
    model_buf = '0;
    state = s_IDLE;
    check_rows("arst");
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
